pwm_bank4: RTL and testbench



---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_timebase.sv | 34 +++
 rtl/pwm_bank4.sv | 72 +++++++
 tb/tb_pwm_bank4.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the four-channel PWM bank.
package pwm_pkg;
    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int PW   = 8;
    localparam int CH_W = 2;

    localparam logic [DW-1:0] DUTY_MAX = {DW{1'b1}};

    typedef logic [DW-1:0] duty_t;
    typedef logic [PW-1:0] presc_t;
endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter; flags the last tick of each period.
module pwm_timebase
    import pwm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] prescale,
    output logic          tick,
    output logic [DW-1:0] cnt,
    output logic          boundary
);

    presc_t presc_cnt_reg;
    duty_t  cnt_reg;

    // >= so that lowering prescale mid-count ticks right away instead of wrapping
    assign tick     = en && (presc_cnt_reg >= prescale);
    assign boundary = tick && (cnt_reg == DUTY_MAX);
    assign cnt      = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= '0;
        end else if (tick) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= cnt_reg + 1'b1;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_bank4.sv
// Four PWM channels with shadow duty registers that take effect at period boundaries.
module pwm_bank4
    import pwm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PW-1:0]   prescale,
    input  logic            we,
    input  logic [CH_W-1:0] ch_sel,
    input  logic [DW-1:0]   duty_in,
    output logic [NCH-1:0]  pwm_out,
    output logic            period_start,
    output logic [NCH-1:0]  pending,
    output logic [DW-1:0]   cnt
);

    logic tick;
    logic boundary;

    duty_t          shadow_reg [NCH];
    duty_t          active_reg [NCH];
    logic [NCH-1:0] pending_reg;
    logic [NCH-1:0] pwm_out_reg;
    logic           period_start_reg;

    pwm_timebase u_timebase (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prescale (prescale),
        .tick     (tick),
        .cnt      (cnt),
        .boundary (boundary)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic wr_sel;
            assign wr_sel = we && (ch_sel == CH_W'(gi));

            // While disabled, active tracks shadow so a restart uses the newest duty
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi]  <= '0;
                    active_reg[gi]  <= '0;
                    pending_reg[gi] <= 1'b0;
                    pwm_out_reg[gi] <= 1'b0;
                end else begin
                    if (wr_sel)
                        shadow_reg[gi] <= duty_in;
                    if (boundary || !en)
                        active_reg[gi] <= shadow_reg[gi];
                    pending_reg[gi] <= en && (wr_sel || (pending_reg[gi] && !boundary));
                    pwm_out_reg[gi] <= en && (cnt < active_reg[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            period_start_reg <= 1'b0;
        else
            period_start_reg <= boundary;
    end

    assign pwm_out      = pwm_out_reg;
    assign pending      = pending_reg;
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_bank4.sv
// Directed bench for pwm_bank4: duty transfer timing, prescaling, enable and reset behaviour.
module tb_pwm_bank4;
    import pwm_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [PW-1:0]   prescale;
    logic            we;
    logic [CH_W-1:0] ch_sel;
    logic [DW-1:0]   duty_in;
    logic [NCH-1:0]  pwm_out;
    logic            period_start;
    logic [NCH-1:0]  pending;
    logic [DW-1:0]   cnt;

    int n_vec = 0;
    int n_err = 0;
    int hi_cnt [NCH];

    always #5 clk = ~clk;

    pwm_bank4 dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .we           (we),
        .ch_sel       (ch_sel),
        .duty_in      (duty_in),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pending      (pending),
        .cnt          (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input int ch, input int d);
        ch_sel  = CH_W'(ch);
        duty_in = DW'(d);
        we      = 1'b1;
        step();
        we      = 1'b0;
        $display("write ch%0d duty %0d (cnt now %0d)", ch, d, cnt);
    endtask

    // exp_n < 0: any distance is fine, only the pulse itself is checked
    task automatic wait_ps(input string tag, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 3000);
        if (exp_n >= 0)
            chk(tag, n, exp_n);
        else
            chk(tag, {31'd0, period_start}, 1);
        chk({tag, "_cnt0"}, cnt, 0);
        $display("period_start after %0d clk", n);
    endtask

    task automatic step_until_cnt(input string tag, input int v);
        int n = 0;
        while (cnt != DW'(v) && n < 3000) begin
            step();
            n++;
        end
        chk(tag, cnt, v);
    endtask

    // Called on a period_start sample; pwm_out lags cnt by one clk, so samples 1..len cover one period
    task automatic measure(input string tag, input int len);
        for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
        for (int i = 0; i < len; i++) begin
            step();
            for (int c = 0; c < NCH; c++)
                if (pwm_out[c]) hi_cnt[c]++;
        end
        chk({tag, "_ps_end"}, {31'd0, period_start}, 1);
        $display("%s high counts: %0d %0d %0d %0d", tag, hi_cnt[0], hi_cnt[1], hi_cnt[2], hi_cnt[3]);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; prescale = '0; we = 1'b0; ch_sel = '0; duty_in = '0;
        repeat (3) @(negedge clk);

        // Test 1: reset state, idle periods of 256 clk
        chk("rst_cnt", cnt, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ps", {31'd0, period_start}, 0);
        rst = 1'b0;
        en  = 1'b1;
        wait_ps("t1_first_ps", 256);
        measure("t1", 256);
        chk("t1_hi_sum", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        // Test 2: ch1 = 64 written mid-period
        step_until_cnt("t2_at10", 10);
        write(1, 64);
        chk("t2_pending", pending, 4'b0010);
        wait_ps("t2_ps", -1);
        chk("t2_pending_clr", pending, 0);
        measure("t2", 256);
        chk("t2_hi1", hi_cnt[1], 64);
        chk("t2_hi_others", hi_cnt[0] + hi_cnt[2] + hi_cnt[3], 0);

        // Test 3: prescale 3, ch0 = 128
        write(0, 128);
        wait_ps("t3_ps", 255);
        prescale = 8'd3;
        measure("t3", 1024);
        chk("t3_hi0", hi_cnt[0], 512);
        chk("t3_hi1", hi_cnt[1], 256);
        prescale = 8'd0;

        // Test 4: write landing in the boundary cycle
        step_until_cnt("t4_at255", 255);
        write(2, 200);
        chk("t4_ps", {31'd0, period_start}, 1);
        chk("t4_pending", pending, 4'b0100);
        measure("t4a", 256);
        chk("t4_hi2_old", hi_cnt[2], 0);
        chk("t4_pending_clr", pending, 0);
        measure("t4b", 256);
        chk("t4_hi2_new", hi_cnt[2], 200);

        // Test 5: duty 255 then 0 on ch3; back-to-back writes, last wins
        write(3, 255);
        wait_ps("t5_ps", 255);
        measure("t5a", 256);
        chk("t5_hi3_255", hi_cnt[3], 255);
        chk("t5_low_at_255", {31'd0, pwm_out[3]}, 0);
        write(3, 10);
        write(3, 0);
        chk("t5_pending", pending, 4'b1000);
        wait_ps("t5_ps2", 254);
        measure("t5b", 256);
        chk("t5_hi3_0", hi_cnt[3], 0);

        // Test 6: disable, write while disabled, re-enable
        en = 1'b0;
        step();
        write(0, 50);
        chk("t6_pending", pending, 0);
        chk("t6_pwm", pwm_out, 0);
        chk("t6_cnt", cnt, 0);
        chk("t6_ps", {31'd0, period_start}, 0);
        step();
        en = 1'b1;
        measure("t6", 256);
        chk("t6_hi0", hi_cnt[0], 50);
        chk("t6_hi1", hi_cnt[1], 64);
        chk("t6_hi2", hi_cnt[2], 200);

        // Reset mid-period, with a write pending and another in the reset cycle
        step_until_cnt("t7_at100", 100);
        write(1, 77);
        chk("t7_pending", pending, 4'b0010);
        rst = 1'b1; ch_sel = 2'd2; duty_in = 8'd99; we = 1'b1;
        step();
        we = 1'b0; rst = 1'b0;
        $display("reset asserted mid-period");
        chk("t7_pwm", pwm_out, 0);
        chk("t7_pending_rst", pending, 0);
        chk("t7_cnt", cnt, 0);
        chk("t7_ps", {31'd0, period_start}, 0);
        wait_ps("t7_ps_first", 256);
        measure("t7", 256);
        chk("t7_hi_sum", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
